// File: rtl/arm_main_fsm_if.sv
// Control bundle between the multicycle ARM main FSM and its datapath.
// master = FSM side (reads instruction fields and memory handshake, drives enables/selects).
interface arm_main_fsm_if #(
  parameter int STATE_W = 4
);
  logic [1:0]         op;
  logic [5:0]         funct;
  logic               mem_ready;
  logic               ir_write;
  logic               next_pc;
  logic               reg_w;
  logic               mem_w;
  logic               branch;
  logic               adr_src;
  logic               alu_src_a;
  logic [1:0]         alu_src_b;
  logic [1:0]         result_src;
  logic               alu_op;
  logic               illegal;
  logic [STATE_W-1:0] dbg_state;

  modport master (
    input  op, funct, mem_ready,
    output ir_write, next_pc, reg_w, mem_w, branch,
           adr_src, alu_src_a, alu_src_b, result_src, alu_op,
           illegal, dbg_state
  );

  modport slave (
    output op, funct, mem_ready,
    input  ir_write, next_pc, reg_w, mem_w, branch,
           adr_src, alu_src_a, alu_src_b, result_src, alu_op,
           illegal, dbg_state
  );
endinterface

// File: rtl/arm_main_fsm.sv
// Multicycle ARM main control FSM: 3-5 cycles per instruction plus one per memory wait cycle.
// Holds in FETCH/MEMREAD/MEMWRITE while mem_ready=0; enables are 0 whenever reset is low.
module arm_main_fsm #(
  parameter int STATE_W = 4
) (
  input  logic          clk,
  input  logic          reset,
  arm_main_fsm_if.master bus
);

  typedef enum logic [STATE_W-1:0] {
    FETCH    = STATE_W'(0),
    DECODE   = STATE_W'(1),
    MEMADR   = STATE_W'(2),
    MEMREAD  = STATE_W'(3),
    MEMWRITE = STATE_W'(4),
    MEMWB    = STATE_W'(5),
    EXECR    = STATE_W'(6),
    EXECI    = STATE_W'(7),
    ALUWB    = STATE_W'(8),
    BRANCH   = STATE_W'(9),
    UNKNOWN  = STATE_W'(10)
  } state_t;

  state_t state;
  state_t state_nxt;

  logic       ir_write_raw;
  logic       next_pc_raw;
  logic       reg_w_raw;
  logic       mem_w_raw;
  logic       branch_raw;
  logic       adr_src;
  logic       alu_src_a;
  logic [1:0] alu_src_b;
  logic [1:0] result_src;
  logic       alu_op;
  logic       illegal;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= FETCH;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = FETCH;
    case (state)
      FETCH:    state_nxt = bus.mem_ready ? DECODE : FETCH;
      DECODE: begin
        case (bus.op)
          2'b00:   state_nxt = bus.funct[5] ? EXECI : EXECR;
          2'b01:   state_nxt = MEMADR;
          2'b10:   state_nxt = BRANCH;
          default: state_nxt = UNKNOWN;
        endcase
      end
      MEMADR:   state_nxt = bus.funct[0] ? MEMREAD : MEMWRITE;
      MEMREAD:  state_nxt = bus.mem_ready ? MEMWB : MEMREAD;
      MEMWRITE: state_nxt = bus.mem_ready ? FETCH : MEMWRITE;
      EXECR:    state_nxt = ALUWB;
      EXECI:    state_nxt = ALUWB;
      default:  state_nxt = FETCH;
    endcase
  end

  always_comb begin
    ir_write_raw = 1'b0;
    next_pc_raw  = 1'b0;
    reg_w_raw    = 1'b0;
    mem_w_raw    = 1'b0;
    branch_raw   = 1'b0;
    adr_src      = 1'b0;
    alu_src_a    = 1'b0;
    alu_src_b    = 2'b00;
    result_src   = 2'b00;
    alu_op       = 1'b0;
    illegal      = 1'b0;
    case (state)
      FETCH: begin
        alu_src_a    = 1'b1;
        alu_src_b    = 2'b10;
        result_src   = 2'b10;
        ir_write_raw = bus.mem_ready;
        next_pc_raw  = bus.mem_ready;
      end
      DECODE: begin
        alu_src_a  = 1'b1;
        alu_src_b  = 2'b10;
        result_src = 2'b10;
      end
      MEMADR: begin
        alu_src_b = 2'b01;
      end
      MEMREAD: begin
        adr_src = 1'b1;
      end
      MEMWRITE: begin
        adr_src   = 1'b1;
        mem_w_raw = bus.mem_ready;
      end
      MEMWB: begin
        result_src = 2'b01;
        reg_w_raw  = 1'b1;
      end
      EXECR: begin
        alu_op = 1'b1;
      end
      EXECI: begin
        alu_src_b = 2'b01;
        alu_op    = 1'b1;
      end
      ALUWB: begin
        reg_w_raw = 1'b1;
      end
      BRANCH: begin
        alu_src_b  = 2'b01;
        result_src = 2'b10;
        branch_raw = 1'b1;
      end
      default: begin
        illegal = 1'b1;
      end
    endcase
  end

  // Enables are gated by reset directly so a mid-instruction reset cannot leak a write
  // even while mem_ready is high in the forced FETCH state.
  assign bus.ir_write   = ir_write_raw & reset;
  assign bus.next_pc    = next_pc_raw  & reset;
  assign bus.reg_w      = reg_w_raw    & reset;
  assign bus.mem_w      = mem_w_raw    & reset;
  assign bus.branch     = branch_raw   & reset;
  assign bus.adr_src    = adr_src;
  assign bus.alu_src_a  = alu_src_a;
  assign bus.alu_src_b  = alu_src_b;
  assign bus.result_src = result_src;
  assign bus.alu_op     = alu_op;
  assign bus.illegal    = illegal;
  assign bus.dbg_state  = state;

endmodule

// File: tb/tb_arm_main_fsm.sv
// Directed bench for arm_main_fsm: per-cycle state code and control vector against hand tables.
module tb_arm_main_fsm;

  logic clk;
  logic reset;
  int   total;
  int   bad;

  arm_main_fsm_if #(.STATE_W(4)) bus ();

  arm_main_fsm #(.STATE_W(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ctrl = {ir_write, next_pc, reg_w, mem_w, branch, adr_src, alu_src_a, alu_src_b, result_src, alu_op, illegal}
  localparam logic [12:0] C_F1   = 13'b11000_0_1_10_10_0_0;
  localparam logic [12:0] C_F0   = 13'b00000_0_1_10_10_0_0;
  localparam logic [12:0] C_DEC  = 13'b00000_0_1_10_10_0_0;
  localparam logic [12:0] C_MADR = 13'b00000_0_0_01_00_0_0;
  localparam logic [12:0] C_MRD  = 13'b00000_1_0_00_00_0_0;
  localparam logic [12:0] C_MW0  = 13'b00000_1_0_00_00_0_0;
  localparam logic [12:0] C_MW1  = 13'b00010_1_0_00_00_0_0;
  localparam logic [12:0] C_MWB  = 13'b00100_0_0_00_01_0_0;
  localparam logic [12:0] C_EXR  = 13'b00000_0_0_00_00_1_0;
  localparam logic [12:0] C_EXI  = 13'b00000_0_0_01_00_1_0;
  localparam logic [12:0] C_AWB  = 13'b00100_0_0_00_00_0_0;
  localparam logic [12:0] C_BR   = 13'b00001_0_0_01_10_0_0;
  localparam logic [12:0] C_UNK  = 13'b00000_0_0_00_00_0_1;
  localparam logic [12:0] C_RST  = 13'b00000_0_1_10_10_0_0;

  function automatic logic [12:0] ctrl_now();
    return {bus.ir_write, bus.next_pc, bus.reg_w, bus.mem_w, bus.branch,
            bus.adr_src, bus.alu_src_a, bus.alu_src_b, bus.result_src,
            bus.alu_op, bus.illegal};
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // Called at a falling edge: drive mem_ready, check this cycle's state/outputs, advance one cycle.
  task automatic cyc(input string tag, input logic mr, input int st, input logic [12:0] ctrl);
    bus.mem_ready = mr;
    #1;
    chk({tag, ".state"}, 32'(bus.dbg_state), 32'(st));
    chk({tag, ".ctrl"},  32'(ctrl_now()),    32'(ctrl));
    @(negedge clk);
  endtask

  task automatic set_instr(input logic [1:0] o, input logic [5:0] f);
    bus.op    = o;
    bus.funct = f;
  endtask

  initial begin
    total         = 0;
    bad           = 0;
    reset         = 1'b0;
    bus.mem_ready = 1'b1;
    bus.op        = 2'b00;
    bus.funct     = 6'b000000;
    @(negedge clk);

    for (int i = 0; i < 3; i++) begin
      #1;
      chk("rst.state", 32'(bus.dbg_state), 32'd0);
      chk("rst.ctrl",  32'(ctrl_now()),    32'(C_RST));
      @(negedge clk);
    end
    reset = 1'b1;

    // ADD register form
    set_instr(2'b00, 6'b000100);
    cyc("add.f",  1'b1, 0, C_F1);
    cyc("add.d",  1'b1, 1, C_DEC);
    cyc("add.ex", 1'b1, 6, C_EXR);
    cyc("add.wb", 1'b1, 8, C_AWB);

    // Immediate form, one fetch wait, mem_ready low in DECODE is ignored
    set_instr(2'b00, 6'b100100);
    cyc("addi.fw", 1'b0, 0, C_F0);
    cyc("addi.f",  1'b1, 0, C_F1);
    cyc("addi.d",  1'b0, 1, C_DEC);
    cyc("addi.ex", 1'b0, 7, C_EXI);
    cyc("addi.wb", 1'b0, 8, C_AWB);

    // LDR with two wait cycles in MEMREAD
    set_instr(2'b01, 6'b011001);
    cyc("ldr.f",   1'b1, 0, C_F1);
    cyc("ldr.d",   1'b1, 1, C_DEC);
    cyc("ldr.adr", 1'b1, 2, C_MADR);
    cyc("ldr.rw0", 1'b0, 3, C_MRD);
    cyc("ldr.rw1", 1'b0, 3, C_MRD);
    cyc("ldr.rd",  1'b1, 3, C_MRD);
    cyc("ldr.wb",  1'b1, 5, C_MWB);

    // STR with one wait cycle in MEMWRITE
    set_instr(2'b01, 6'b011000);
    cyc("str.f",   1'b1, 0, C_F1);
    cyc("str.d",   1'b1, 1, C_DEC);
    cyc("str.adr", 1'b1, 2, C_MADR);
    cyc("str.ww",  1'b0, 4, C_MW0);
    cyc("str.wr",  1'b1, 4, C_MW1);

    // Branch
    set_instr(2'b10, 6'b000000);
    cyc("b.f",  1'b1, 0, C_F1);
    cyc("b.d",  1'b1, 1, C_DEC);
    cyc("b.br", 1'b1, 9, C_BR);

    // Illegal opcode
    set_instr(2'b11, 6'b000000);
    cyc("ill.f", 1'b1, 0, C_F1);
    cyc("ill.d", 1'b1, 1, C_DEC);
    cyc("ill.u", 1'b1, 10, C_UNK);

    // Reset asserted in ALUWB
    set_instr(2'b00, 6'b000100);
    cyc("rsw.f",  1'b1, 0, C_F1);
    cyc("rsw.d",  1'b1, 1, C_DEC);
    cyc("rsw.ex", 1'b1, 6, C_EXR);
    bus.mem_ready = 1'b1;
    #1;
    chk("rsw.wb.state", 32'(bus.dbg_state), 32'd8);
    chk("rsw.wb.regw",  32'(bus.reg_w),     32'd1);
    #2;
    reset = 1'b0;
    #1;
    chk("rsw.async.state", 32'(bus.dbg_state), 32'd0);
    chk("rsw.async.regw",  32'(bus.reg_w),     32'd0);
    chk("rsw.async.ctrl",  32'(ctrl_now()),    32'(C_RST));
    @(negedge clk);
    #1;
    chk("rsw.hold.state", 32'(bus.dbg_state), 32'd0);
    chk("rsw.hold.ctrl",  32'(ctrl_now()),    32'(C_RST));
    @(negedge clk);
    reset = 1'b1;
    cyc("rsw.rel", 1'b1, 0, C_F1);
    cyc("rsw.d2",  1'b1, 1, C_DEC);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/arm_main_fsm.md
Name: arm_main_fsm

Overview:
- Main control state machine for the multicycle ARM datapath.
- Sequences each instruction through fetch, decode, execute, memory and writeback.
- Drives the write enables (IRWrite, NextPC, RegW, MemW, Branch) that gate the datapath's enabled registers.
- Drives the datapath mux selects and the ALU decoder request.
- Adds a memory wait handshake (mem_ready) so the FSM can hold in memory-access states.

Parameters:
- STATE_W, 4, width of state encoding and of the dbg_state port (must be ≥4).

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-low reset (0 = in reset)
- op  input  2  Instr[27:26]
- funct  input  6  Instr[25:20]; bit5 = I, bit0 = L/S
- mem_ready  input  1  memory completes the current access this cycle
- ir_write  output  1  instruction register enable
- next_pc  output  1  PC update request
- reg_w  output  1  register file write request
- mem_w  output  1  data memory write
- branch  output  1  branch request
- adr_src  output  1  0 = PC, 1 = ALUOut
- alu_src_a  output  1  0 = RD1, 1 = PC
- alu_src_b  output  2  00 = RD2, 01 = ExtImm, 10 = const 4
- result_src  output  2  00 = ALUOut, 01 = Data, 10 = ALUResult
- alu_op  output  1  1 = ALU decoder uses funct; 0 = add
- illegal  output  1  FSM is in UNKNOWN
- dbg_state  output  STATE_W  current state code

Behaviour:
- Reset:
  - reset=0 forces state FETCH asynchronously.
  - While reset=0, all enables (ir_write, next_pc, reg_w, mem_w, branch) are 0.
  - Select outputs take FETCH values. illegal=0. dbg_state=0.
- State codes:
  - FETCH=0, DECODE=1, MEMADR=2, MEMREAD=3, MEMWRITE=4, MEMWB=5
  - EXECR=6, EXECI=7, ALUWB=8, BRANCH=9, UNKNOWN=10
  - Codes 11–15 are unreachable and decode as UNKNOWN.
- Transitions (sampled on the rising edge):
  - FETCH: goes to DECODE if mem_ready=1; otherwise holds.
  - DECODE, by op:
    - op=01 -> MEMADR
    - op=00 and funct[5]=0 -> EXECR
    - op=00 and funct[5]=1 -> EXECI
    - op=10 -> BRANCH
    - op=11 -> UNKNOWN
  - MEMADR: funct[0]=1 -> MEMREAD; funct[0]=0 -> MEMWRITE.
  - MEMREAD: goes to MEMWB if mem_ready=1; otherwise holds.
  - MEMWRITE: goes to FETCH if mem_ready=1; otherwise holds.
  - EXECR and EXECI -> ALUWB.
  - MEMWB, ALUWB, BRANCH and UNKNOWN -> FETCH.
- Outputs are Moore decode of state except where noted. Unlisted signals are 0; there are no don't-cares.
  - FETCH:
    - adr_src=0, alu_src_a=1, alu_src_b=10, result_src=10, alu_op=0
    - ir_write = next_pc = mem_ready (combinational gating)
  - DECODE: alu_src_a=1, alu_src_b=10, result_src=10.
  - MEMADR: alu_src_a=0, alu_src_b=01.
  - MEMREAD: adr_src=1, result_src=00.
  - MEMWRITE: adr_src=1, result_src=00, mem_w = mem_ready.
  - MEMWB: result_src=01, reg_w=1.
  - EXECR: alu_src_b=00, alu_op=1.
  - EXECI: alu_src_b=01, alu_op=1.
  - ALUWB: result_src=00, reg_w=1.
  - BRANCH: alu_src_a=0, alu_src_b=01, result_src=10, branch=1.
  - UNKNOWN: illegal=1, all enables 0.
- Instruction latency with mem_ready held at 1:
  - data-processing: 4 cycles
  - LDR: 5 cycles
  - STR: 4 cycles
  - B: 3 cycles
  - Each wait cycle adds 1.
- Each enable pulses for exactly one cycle per instruction, or holds 0 while waiting.
- mem_ready is ignored outside FETCH, MEMREAD and MEMWRITE.
- Reset mid-instruction: the FSM returns to FETCH immediately. Enables drop in the same cycle, with no partial write.
- op/funct are sampled only in DECODE and MEMADR. They must come from the instruction register, which is stable after FETCH.

Test Plan:
- Reset and hold: reset=0 for 3 cycles with mem_ready=1 -> dbg_state=0 and all enables 0. Release reset -> ir_write=next_pc=1 in the first cycle.
- ADD register form (op=00, funct=000100), mem_ready=1:
  - states go 0,1,6,8,0
  - reg_w=1 only in state 8; alu_op=1 in state 6
- LDR with wait (op=01, funct=011001), mem_ready=0 for 2 cycles in MEMREAD:
  - states go 0,1,2,3,3,3,5,0
  - result_src=01 and reg_w=1 in state 5
- STR with wait (op=01, funct=011000), mem_ready=0 in the first MEMWRITE cycle:
  - mem_w=0 then 1
  - states go 0,1,2,4,4,0
- Branch (op=10):
  - states go 0,1,9,0
  - branch=1 for one cycle, alu_src_b=01
- Illegal and reset:
  - op=11 -> states go 0,1,10,0, with illegal=1 for one cycle and no enables.
  - Separately, reset asserted in ALUWB -> reg_w falls to 0 the same cycle and the state returns to 0.
